// File: rtl/seq7_checker.sv
// Receive-side checker for the 7-state {Q1,Q2,Q3} sequence generator.
// Acquires lock on a clean run of successors, counts errors while locked, drops lock on misses or 000.
module seq7_checker #(
  parameter int LOCK_N = 3,
  parameter int MISS_N = 2,
  parameter int CW     = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          Q1,
  input  logic          Q2,
  input  logic          Q3,
  input  logic          CLR,
  output logic          LOCKED,
  output logic          ERR,
  output logic          WRAP,
  output logic [CW-1:0] ERR_CNT
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam logic [2:0]    LOCK_C  = 3'(LOCK_N);
  localparam logic [2:0]    MISS_C  = 3'(MISS_N);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t     state_reg;
  logic [2:0] prev_reg;
  logic [2:0] good_cnt_reg;
  logic [2:0] miss_cnt_reg;
  logic [2:0] d;
  logic       legal;
  logic       match;
  logic       err_inc;

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      3'b100:  succ = 3'b110;
      3'b110:  succ = 3'b111;
      3'b111:  succ = 3'b011;
      3'b011:  succ = 3'b001;
      3'b001:  succ = 3'b010;
      3'b010:  succ = 3'b101;
      3'b101:  succ = 3'b100;
      default: succ = 3'b000;
    endcase
  endfunction

  assign d     = {Q1, Q2, Q3};
  assign legal = (d != 3'b000);
  // A legal code is required so a 000 prev can never make 000 look like a match.
  assign match = legal && (d == succ(prev_reg));
  assign err_inc = EN && (state_reg == LOCK) && !match;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= HUNT;
      prev_reg     <= 3'b000;
      good_cnt_reg <= 3'd0;
      miss_cnt_reg <= 3'd0;
      LOCKED       <= 1'b0;
      ERR          <= 1'b0;
      WRAP         <= 1'b0;
      ERR_CNT      <= '0;
    end else begin
      ERR  <= 1'b0;
      WRAP <= 1'b0;

      // Clear wins over a coincident increment; saturated count ignores increments.
      if (CLR)
        ERR_CNT <= '0;
      else if (err_inc && (ERR_CNT != CNT_MAX))
        ERR_CNT <= ERR_CNT + 1'b1;

      if (EN) begin
        prev_reg <= d;
        case (state_reg)
          HUNT: begin
            if (legal) begin
              state_reg    <= SYNC;
              good_cnt_reg <= 3'd0;
            end
          end
          SYNC: begin
            if (!legal) begin
              state_reg <= HUNT;
            end else if (match) begin
              if (good_cnt_reg + 3'd1 == LOCK_C) begin
                state_reg    <= LOCK;
                miss_cnt_reg <= 3'd0;
                LOCKED       <= 1'b1;
              end else begin
                good_cnt_reg <= good_cnt_reg + 3'd1;
              end
            end else begin
              good_cnt_reg <= 3'd0;
            end
          end
          LOCK: begin
            if (!legal) begin
              ERR       <= 1'b1;
              state_reg <= HUNT;
              LOCKED    <= 1'b0;
            end else if (match) begin
              miss_cnt_reg <= 3'd0;
              WRAP         <= (d == 3'b100);
            end else begin
              ERR <= 1'b1;
              if (miss_cnt_reg + 3'd1 == MISS_C) begin
                state_reg <= HUNT;
                LOCKED    <= 1'b0;
              end else begin
                miss_cnt_reg <= miss_cnt_reg + 3'd1;
              end
            end
          end
          default: begin
            state_reg <= HUNT;
            LOCKED    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seq7_checker.md
# seq7_checker

Receive-side checker for the 7-state, 3-bit sequence generator in the digital-logic exercise set. Each enabled clock it samples a 3-bit code {Q1,Q2,Q3} and checks it against the generator's fixed cycle 100 → 110 → 111 → 011 → 001 → 010 → 101 → 100. It acquires lock after a run of correct successors, flags and counts errors while locked, and drops lock on repeated mismatches or on the illegal code 000. It sits downstream of a generator or on a test harness, observing the generator outputs.

## Interface
- LOCK_N, 3: consecutive correct successors needed in SYNC to enter LOCKED (1..7).
- MISS_N, 2: consecutive mismatches in LOCKED that force HUNT (1..7).
- CW, 8: width of ERR_CNT.
- CLK  input  1  rising-edge clock, the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  sample enable; the code is taken only on edges where EN=1.
- Q1, Q2, Q3  input  1 each  observed code, D = {Q1,Q2,Q3}.
- CLR  input  1  synchronous clear of ERR_CNT, acts regardless of EN.
- LOCKED  output  1  high while the FSM is in LOCKED.
- ERR  output  1  one-cycle pulse for each error detected in LOCKED.
- WRAP  output  1  one-cycle pulse when a correct 100 is received in LOCKED (one full period).
- ERR_CNT  output  CW  saturating error count.

## Operation
- succ(): 100→110, 110→111, 111→011, 011→001, 001→010, 010→101, 101→100. 000 is illegal.
- Internal registers: state (HUNT/SYNC/LOCKED), prev[2:0], good_cnt, miss_cnt.
- On every enabled edge, prev ← D. The exception is illegal D, where prev is don't-care.
- HUNT:
  - Legal D → SYNC, good_cnt ← 0.
  - 000 → stay in HUNT.
- SYNC:
  - D == succ(prev) → good_cnt+1. When that equals LOCK_N, go to LOCKED with miss_cnt ← 0.
  - Legal mismatch → good_cnt ← 0, stay in SYNC.
  - 000 → HUNT.
- LOCKED:
  - Match → miss_cnt ← 0. WRAP=1 if D==100.
  - Legal mismatch → ERR=1, ERR_CNT+1, miss_cnt+1. When that equals MISS_N, go to HUNT. The mismatch re-anchors prev, so the next check uses succ(D).
  - 000 → ERR=1, ERR_CNT+1, HUNT immediately, independent of miss_cnt.
- ERR and WRAP are never produced in HUNT or SYNC. The two never assert in the same cycle.
- ERR_CNT:
  - Saturates at 2^CW−1. An increment while saturated is ignored.
  - CLR coincident with an increment gives ERR_CNT = 0 (clear wins).

## Timing
- All outputs are registered. A sample taken at edge k produces its LOCKED/ERR/WRAP/ERR_CNT effect immediately after edge k, valid during cycle k+1.
- ERR and WRAP are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- EN=0 edge: all state holds and ERR=WRAP=0. A gap in EN does not break the successor check; the next enabled sample is compared with succ(prev).
- Lock latency from HUNT with a clean stream: the 1st sample enters SYNC, and LOCKED rises after sample LOCK_N+1 (4th sample at defaults).
- Unlock latency: LOCKED falls after the MISS_N-th consecutive mismatch, or after a single 000.
- Reset (RST_N=0, asynchronous):
  - State → HUNT; prev, good_cnt, miss_cnt → 0.
  - LOCKED=0, ERR=0, WRAP=0, ERR_CNT=0.
  - Asserting reset mid-lock clears everything at once.
  - Release is synchronous to the next CLK edge; the first enabled edge after release is a HUNT sample.

## Test plan
- Reset, then feed 100,110,111,011 with EN=1 → LOCKED=0 after samples 1–3 and LOCKED=1 after the 4th; ERR=0 throughout. Continue 001,010,101,100 → single WRAP pulse after the 100; ERR_CNT=0.
- Locked stream, inject one wrong code (expected 001, send 010), then continue with succ(010)=101 → one ERR pulse, ERR_CNT=1, LOCKED stays 1.
- Locked stream, two consecutive wrong codes (e.g. 110 then 100 where neither matches) → ERR pulses on both, ERR_CNT=2, LOCKED=0 after the second; then 4 clean codes relock.
- Locked stream, send 000 → ERR pulse, ERR_CNT+1, LOCKED=0 on that edge. Then 000,000 → stay in HUNT with no ERR.
- CW=2: force 5 errors → ERR_CNT saturates at 3. CLR asserted on the same edge as an error → ERR_CNT=0. Toggle EN low for 3 cycles mid-lock → no change, and the stream resumes without ERR.
- Assert RST_N low between edges while LOCKED with ERR_CNT=2 → all outputs 0 immediately, without waiting for a CLK edge.
